// File: rtl/capture_dump.sv
// Purpose: read the 512-entry circular trace RAM oldest-first after a capture and stream it to the host transmitter.
// Latency: request accepted at edge 0 -> en in cycle 1 -> send_dump from cycle 3; 3 cycles per sample at full rate.
// Backpressure: send_dump/dump_data held while dump_ready is low; no RAM read is issued until the sample is taken.
module capture_dump #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_dump,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] trace_end,
    input  logic [DATA_W-1:0] rdata,
    input  logic              dump_ready,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              send_dump,
    output logic              dump_finished,
    output logic              clr_capture_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = '1;

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cnt;

    // The read address is always the current pointer; en alone qualifies it.
    assign addr = rd_addr;

    // Dump sequencer: all outputs registered, en raised on entry to READ so it is high for exactly that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            en               <= 1'b0;
            send_dump        <= 1'b0;
            dump_finished    <= 1'b0;
            clr_capture_done <= 1'b0;
            busy             <= 1'b0;
            dump_data        <= '0;
            rd_addr          <= '0;
            cnt              <= '0;
        end else begin
            en               <= 1'b0;
            dump_finished    <= 1'b0;
            clr_capture_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The oldest sample sits just after the newest one in the circular buffer.
                    if (start_dump && capture_done) begin
                        rd_addr <= trace_end + 1'b1;
                        cnt     <= '0;
                        en      <= 1'b1;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    dump_data <= rdata;
                    send_dump <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (send_dump && dump_ready) begin
                        send_dump <= 1'b0;
                        if (cnt == LAST_CNT) begin
                            dump_finished    <= 1'b1;
                            clr_capture_done <= 1'b1;
                            state            <= DONE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                            en      <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    send_dump <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_dump.sv
// Bench for capture_dump: trace RAM model plus scoreboard of expected read addresses and samples.
// Stimulus process pushes expectations; monitor pops and compares on every en and every transfer.
// Directed scenarios: full dumps, wrap, backpressure, ignored requests, mid-dump reset.
module tb_capture_dump;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_dump;
    logic              capture_done;
    logic [ADDR_W-1:0] trace_end;
    logic [DATA_W-1:0] rdata;
    logic              dump_ready;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dump_data;
    logic              send_dump;
    logic              dump_finished;
    logic              clr_capture_done;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    int addr_q[$];
    int data_q[$];
    int n_pass  = 0;
    int n_total = 0;
    int xfer_cnt = 0;
    int en_cnt   = 0;
    int fin_cnt  = 0;

    capture_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_dump       (start_dump),
        .capture_done     (capture_done),
        .trace_end        (trace_end),
        .rdata            (rdata),
        .dump_ready       (dump_ready),
        .en               (en),
        .addr             (addr),
        .dump_data        (dump_data),
        .send_dump        (send_dump),
        .dump_finished    (dump_finished),
        .clr_capture_done (clr_capture_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read trace RAM, one cycle latency.
    always @(posedge clk) begin
        if (en) rdata <= mem[addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares every RAM read and every accepted sample against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en) begin
                en_cnt++;
                check("en_while_busy", int'(busy), 1);
                if (addr_q.size() == 0) check("unexpected_en_addr", int'(addr), -1);
                else check("rd_addr", int'(addr), addr_q.pop_front());
            end
            if (send_dump && dump_ready) begin
                xfer_cnt++;
                if (data_q.size() == 0) check("unexpected_sample", int'(dump_data), -1);
                else check("dump_data", int'(dump_data), data_q.pop_front());
            end
            if (dump_finished || clr_capture_done) begin
                fin_cnt++;
                check("finish_clr_together", int'(dump_finished), int'(clr_capture_done));
                check("busy_in_done", int'(busy), 1);
                check("en_in_done", int'(en), 0);
            end
        end
    end

    task automatic push_dump(input int te);
        for (int i = 1; i <= DEPTH; i++) begin
            int a;
            a = (te + i) % DEPTH;
            addr_q.push_back(a);
            data_q.push_back(a % 256);
        end
    endtask

    // Pulse start_dump over one edge; returns after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start_dump = 1'b1;
        @(posedge clk);
        #1 start_dump = 1'b0;
    endtask

    task automatic start_and_latency(input string name);
        int lat;
        pulse_start();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (send_dump) break;
        end
        check(name, lat, 3);
    endtask

    task automatic wait_finish(input string name);
        int f0;
        bit seen;
        f0 = fin_cnt;
        seen = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #3;
            if (fin_cnt != f0) begin
                seen = 1;
                break;
            end
        end
        check({name, "_finished"}, int'(seen), 1);
        check({name, "_one_pulse"}, fin_cnt - f0, 1);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_fin_low_after"}, int'(dump_finished), 0);
        check({name, "_clr_low_after"}, int'(clr_capture_done), 0);
        check({name, "_addr_q_empty"}, addr_q.size(), 0);
        check({name, "_data_q_empty"}, data_q.size(), 0);
    endtask

    initial begin
        int x0;
        logic [DATA_W-1:0] held;
        for (int i = 0; i < DEPTH; i++) mem[i] = i[DATA_W-1:0];
        rst_n        = 1'b0;
        start_dump   = 1'b0;
        capture_done = 1'b0;
        trace_end    = '0;
        dump_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_en", int'(en), 0);
        check("rst_send_dump", int'(send_dump), 0);
        check("rst_finished", int'(dump_finished), 0);
        check("rst_clr", int'(clr_capture_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dump_data", int'(dump_data), 0);
        check("rst_addr", int'(addr), 0);

        // 1: trace_end = 0x1FF, addresses 0..0x1FF
        trace_end    = 9'h1FF;
        capture_done = 1'b1;
        push_dump(9'h1FF);
        x0 = xfer_cnt;
        start_and_latency("t1_latency");
        wait_finish("t1");
        check("t1_xfers", xfer_cnt - x0, DEPTH);

        // 2: wrap from trace_end = 0x0A4
        trace_end = 9'h0A4;
        push_dump(9'h0A4);
        x0 = xfer_cnt;
        start_and_latency("t2_latency");
        wait_finish("t2");
        check("t2_xfers", xfer_cnt - x0, DEPTH);

        // 3: backpressure on sample 10
        trace_end = 9'h1FF;
        push_dump(9'h1FF);
        x0 = xfer_cnt;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (send_dump && (xfer_cnt - x0) == 10) break;
        end
        check("t3_reached_sample10", xfer_cnt - x0, 10);
        dump_ready = 1'b0;
        held = dump_data;
        check("t3_held_value", int'(held), 10);
        repeat (5) begin
            @(posedge clk);
            #2;
            check("t3_send_held", int'(send_dump), 1);
            check("t3_data_stable", int'(dump_data), int'(held));
            check("t3_no_en", int'(en), 0);
        end
        dump_ready = 1'b1;
        wait_finish("t3");
        check("t3_xfers", xfer_cnt - x0, DEPTH);

        // 4: request without capture_done is dropped
        capture_done = 1'b0;
        x0 = en_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        check("t4_idle", int'(busy), 0);
        capture_done = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_no_late_dump", int'(busy), 0);
        check("t4_no_en", en_cnt - x0, 0);

        // 5: reset at sample 37 abandons the dump
        trace_end = 9'h1FF;
        push_dump(9'h1FF);
        x0 = fin_cnt;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            if (xfer_cnt - (xfer_cnt % DEPTH) >= 0 && send_dump && data_q.size() == DEPTH - 37) break;
        end
        check("t5_at_sample37", DEPTH - data_q.size(), 37);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        addr_q.delete();
        data_q.delete();
        @(negedge clk);
        check("t5_busy", int'(busy), 0);
        check("t5_en", int'(en), 0);
        check("t5_send", int'(send_dump), 0);
        check("t5_data", int'(dump_data), 0);
        check("t5_fin", int'(dump_finished), 0);
        check("t5_clr", int'(clr_capture_done), 0);
        repeat (5) @(negedge clk);
        check("t5_no_finish_pulse", fin_cnt - x0, 0);
        trace_end = 9'h010;
        push_dump(9'h010);
        x0 = xfer_cnt;
        start_and_latency("t5_restart_latency");
        wait_finish("t5");
        check("t5_xfers", xfer_cnt - x0, DEPTH);

        // 6: new request and trace_end change mid-dump are ignored
        trace_end = 9'h050;
        push_dump(9'h050);
        x0 = xfer_cnt;
        pulse_start();
        repeat (60) @(negedge clk);
        trace_end = 9'h123;
        pulse_start();
        wait_finish("t6");
        check("t6_xfers", xfer_cnt - x0, DEPTH);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/capture_dump.md
Name: capture_dump

Overview:
Read-side counterpart of the capture controller. Once a capture completes (capture_done set), a start_dump request makes this block read the full 512-entry circular trace RAM, oldest sample first, using the capture's saved trace_end pointer. It streams each sample to the host-side transmitter with a valid/ready handshake. After the last sample it pulses dump_finished and clr_capture_done, which re-enables capture.

Parameters:
ADDR_W, 9, RAM address width; depth = 2**ADDR_W entries
DATA_W, 8, sample width of the RAM read port and dump_data

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start_dump  input  1  dump request; sampled only in IDLE
capture_done  input  1  capture complete; trace RAM holds a valid trace
trace_end  input  ADDR_W  address of the newest sample written by capture
rdata  input  DATA_W  RAM read data, valid one clk after en/addr
dump_ready  input  1  transmitter can accept dump_data this cycle
en  output  1  RAM read enable (we is never driven here; write side owns it)
addr  output  ADDR_W  RAM read address
dump_data  output  DATA_W  registered sample presented to transmitter
send_dump  output  1  dump_data valid; held until dump_ready
dump_finished  output  1  one-cycle pulse after last sample accepted
clr_capture_done  output  1  one-cycle pulse, coincident with dump_finished
busy  output  1  high in every state except IDLE

Behaviour:
- Reset is synchronous. On a clk edge with rst_n=0: state=IDLE, en=0, send_dump=0, dump_finished=0, clr_capture_done=0, busy=0, dump_data=0, rd_addr=0, cnt=0.
- Reset mid-dump abandons the dump with no finish or clear pulse; capture_done is left untouched.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: if start_dump && capture_done, then rd_addr <= trace_end+1 (mod 2**ADDR_W), cnt <= 0, go to READ. Otherwise stay.
  - start_dump with capture_done=0 is ignored; no pending request is remembered.
- READ: en=1, addr=rd_addr, go to WAIT. addr is combinational from rd_addr; outside READ, en=0 and addr=rd_addr.
- WAIT: RAM latency cycle. dump_data <= rdata at the end of this cycle, then go to SEND.
- SEND: send_dump=1, dump_data stable.
  - Transfer happens on a cycle where send_dump && dump_ready.
  - On transfer with cnt==2**ADDR_W-1, go to DONE.
  - On any other transfer: cnt <= cnt+1, rd_addr <= rd_addr+1 (wraps 0x1FF -> 0x000), go to READ.
  - With dump_ready=0: hold state, send_dump stays 1, dump_data unchanged, en=0.
- DONE: dump_finished=1 and clr_capture_done=1 for exactly one cycle, then go to IDLE.
- cnt is ADDR_W bits; exactly 2**ADDR_W samples per dump. The address sequence is trace_end+1, trace_end+2, ..., trace_end, modulo 2**ADDR_W.
- trace_end is sampled only in IDLE on acceptance; later changes have no effect on the dump in progress.
- start_dump while busy=1 is ignored.
- Latency: start_dump accepted at edge 0 -> en=1 during cycle 1 -> send_dump=1 from cycle 3.
  - With dump_ready tied high, each sample takes 3 cycles.
  - Full dump: 3*512 cycles from acceptance to the last transfer, then the DONE pulse on the next cycle.
- en is never asserted in IDLE or DONE, so the capture side may own the RAM then.

Test Plan:
1. RAM preloaded mem[i]=i[7:0], trace_end=0x1FF, capture_done=1, dump_ready=1, start_dump pulse -> send_dump first asserted 3 cycles later; addresses 0x000..0x1FF in order; data 0x00..0xFF twice; dump_finished and clr_capture_done high together for 1 cycle; busy low afterwards.
2. Same RAM, trace_end=0x0A4 -> first addr 0x0A5, wraps 0x1FF->0x000, last addr 0x0A4; exactly 512 transfers.
3. Backpressure: dump_ready low for 5 cycles on sample 10 -> send_dump held 5+ cycles, dump_data constant, en=0 throughout; no sample lost or duplicated.
4. start_dump with capture_done=0 -> remains IDLE, en never asserted. Raising capture_done later without a new start_dump produces no dump.
5. rst_n low for 1 cycle at sample 37 -> next cycle IDLE, all outputs 0, no dump_finished pulse. A new start_dump then restarts from trace_end+1.
6. Second start_dump pulse mid-dump and a trace_end change mid-dump -> ignored; the address sequence follows the original trace_end.
